// File: rtl/gearbox_pkg.sv
// Shared widths and derivation helpers for the TX gearbox.
package gearbox_pkg;

  localparam int DEF_IN_W  = 67;
  localparam int DEF_OUT_W = 20;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      r = r + 1;
    end
    return r;
  endfunction

  // Worst case storage: OUT_W-1 leftover bits plus one full block.
  function automatic int calc_cap(input int in_w, input int out_w);
    return in_w + out_w - 1;
  endfunction

  function automatic int calc_cnt_w(input int in_w, input int out_w);
    return clog2(calc_cap(in_w, out_w) + 1);
  endfunction

endpackage

// File: rtl/gearbox_tx_flow_if.sv
// Block-in / word-out handshake bundle between framer, gearbox and transceiver.
interface gearbox_tx_flow_if import gearbox_pkg::*; #(
  parameter int IN_W  = DEF_IN_W,
  parameter int OUT_W = DEF_OUT_W,
  parameter int CNT_W = calc_cnt_w(IN_W, OUT_W)
) ();

  logic [IN_W-1:0]  DATA_IN;
  logic             DATA_IN_VALID;
  logic             DATA_IN_READY;
  logic [OUT_W-1:0] DATA_OUT;
  logic             UNDERFLOW;
  logic             DROP_ERR;
  logic [CNT_W-1:0] FILL_LEVEL;

  modport master (
    output DATA_IN, DATA_IN_VALID,
    input  DATA_IN_READY, DATA_OUT, UNDERFLOW, DROP_ERR, FILL_LEVEL
  );

  modport slave (
    input  DATA_IN, DATA_IN_VALID,
    output DATA_IN_READY, DATA_OUT, UNDERFLOW, DROP_ERR, FILL_LEVEL
  );

endinterface

// File: rtl/gearbox_aligner.sv
// Places an incoming block just below the res bits still held, MSB-aligned in CAP-bit storage.
module gearbox_aligner import gearbox_pkg::*; #(
  parameter  int IN_W  = DEF_IN_W,
  parameter  int OUT_W = DEF_OUT_W,
  localparam int CAP   = calc_cap(IN_W, OUT_W),
  localparam int CNT_W = calc_cnt_w(IN_W, OUT_W)
) (
  input  logic [IN_W-1:0]  i_data,
  input  logic [CNT_W-1:0] i_res,
  output logic [CAP-1:0]   o_aligned
);

  logic [CAP-1:0] w_ext;

  assign w_ext = CAP'(i_data) << (OUT_W - 1);

  // One shift per possible leftover count; res never reaches OUT_W when a block is accepted.
  always_comb begin
    o_aligned = '0;
    for (int k = 0; k < OUT_W; k++) begin
      o_aligned = (i_res == CNT_W'(k)) ? (w_ext >> k) : o_aligned;
    end
  end

endmodule

// File: rtl/gearbox_tx_flow.sv
// TX gearbox: packs IN_W-bit blocks into OUT_W-bit lane words and owns upstream flow control.
module gearbox_tx_flow import gearbox_pkg::*; #(
  parameter int IN_W        = DEF_IN_W,
  parameter int OUT_W       = DEF_OUT_W,
  parameter int REVERSE_OUT = 1
) (
  input  logic              USER_CLK,
  input  logic              SYSTEM_RESET,
  gearbox_tx_flow_if.slave  bus
);

  localparam int CAP   = calc_cap(IN_W, OUT_W);
  localparam int CNT_W = calc_cnt_w(IN_W, OUT_W);

  logic [CAP-1:0]   r_storage;
  logic [CNT_W-1:0] r_cnt;
  logic             r_drop_err;

  logic [CNT_W-1:0] w_drain;
  logic [CNT_W-1:0] w_res;
  logic [CNT_W:0]   w_need;
  logic             w_ready;
  logic             w_accept;
  logic             w_underflow;
  logic [CAP-1:0]   w_aligned;
  logic [CAP-1:0]   w_ins;
  logic [OUT_W-1:0] w_word;
  logic [OUT_W-1:0] w_word_out;

  // Drain, leftover and admission; ready depends only on the held count.
  always_comb begin
    if (r_cnt < CNT_W'(OUT_W)) begin
      w_underflow = 1'b1;
      w_drain     = r_cnt;
    end else begin
      w_underflow = 1'b0;
      w_drain     = CNT_W'(OUT_W);
    end
    w_res    = r_cnt - w_drain;
    w_need   = {1'b0, w_res} + (CNT_W+1)'(IN_W);
    w_ready  = (w_need <= (CNT_W+1)'(CAP));
    w_accept = bus.DATA_IN_VALID & w_ready;
    w_ins    = w_accept ? w_aligned : '0;
  end

  gearbox_aligner #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W)
  ) u_aligner (
    .i_data    (bus.DATA_IN),
    .i_res     (w_res),
    .o_aligned (w_aligned)
  );

  // Storage shifts out one word per cycle; zeros fill from below so short words are zero padded.
  always_ff @(posedge USER_CLK) begin
    if (SYSTEM_RESET) begin
      r_storage  <= '0;
      r_cnt      <= '0;
      r_drop_err <= 1'b0;
    end else begin
      r_storage  <= (r_storage << OUT_W) | w_ins;
      r_cnt      <= w_res + (w_accept ? CNT_W'(IN_W) : '0);
      r_drop_err <= bus.DATA_IN_VALID & ~w_ready;
    end
  end

  assign w_word = r_storage[CAP-1 -: OUT_W];

  generate
    if (REVERSE_OUT != 0) begin : g_rev
      assign w_word_out = {<<{w_word}};
    end else begin : g_fwd
      assign w_word_out = w_word;
    end
  endgenerate

  assign bus.DATA_OUT      = w_word_out;
  assign bus.DATA_IN_READY = w_ready;
  assign bus.UNDERFLOW     = w_underflow;
  assign bus.DROP_ERR      = r_drop_err;
  assign bus.FILL_LEVEL    = r_cnt;

endmodule

// File: tb/tb_gearbox_tx_flow.sv
// Bench for gearbox_tx_flow: bit-queue scoreboard plus fixed-sequence scenario tasks.
module tb_gearbox_tx_flow;

  logic clk;
  logic rst_a, rst_b, rst_c;
  int   checks = 0;
  int   errors = 0;

  bit   q_a[$];
  bit   q_c[$];
  bit   exp_drop_a = 1'b0;
  bit   exp_drop_c = 1'b0;

  gearbox_tx_flow_if #(.IN_W(67), .OUT_W(20)) if_a ();
  gearbox_tx_flow_if #(.IN_W(67), .OUT_W(20)) if_b ();
  gearbox_tx_flow_if #(.IN_W(66), .OUT_W(32)) if_c ();

  gearbox_tx_flow #(.IN_W(67), .OUT_W(20), .REVERSE_OUT(0)) dut_a (
    .USER_CLK(clk), .SYSTEM_RESET(rst_a), .bus(if_a));
  gearbox_tx_flow #(.IN_W(67), .OUT_W(20), .REVERSE_OUT(1)) dut_b (
    .USER_CLK(clk), .SYSTEM_RESET(rst_b), .bus(if_b));
  gearbox_tx_flow #(.IN_W(66), .OUT_W(32), .REVERSE_OUT(0)) dut_c (
    .USER_CLK(clk), .SYSTEM_RESET(rst_c), .bus(if_c));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One cycle on instance A: drive, compare against the bit queue, then advance the model.
  task automatic step_a(input bit valid, input logic [66:0] data, output bit acc);
    logic [19:0] exp_word;
    bit exp_rdy;
    bit exp_uf;
    int n;
    @(negedge clk);
    if_a.DATA_IN       = data;
    if_a.DATA_IN_VALID = valid;
    #1;
    n = (q_a.size() < 20) ? q_a.size() : 20;
    exp_word = '0;
    for (int i = 0; i < n; i++) exp_word[19-i] = q_a[i];
    exp_rdy = (q_a.size() <= 39);
    exp_uf  = (q_a.size() < 20);
    checks++;
    if (if_a.DATA_OUT !== exp_word) begin
      errors++; $display("FAIL a_data_out got %h exp %h", if_a.DATA_OUT, exp_word);
    end
    checks++;
    if (if_a.DATA_IN_READY !== exp_rdy) begin
      errors++; $display("FAIL a_ready got %b exp %b", if_a.DATA_IN_READY, exp_rdy);
    end
    checks++;
    if (if_a.UNDERFLOW !== exp_uf) begin
      errors++; $display("FAIL a_underflow got %b exp %b", if_a.UNDERFLOW, exp_uf);
    end
    checks++;
    if (if_a.FILL_LEVEL !== 7'(q_a.size())) begin
      errors++; $display("FAIL a_fill got %0d exp %0d", if_a.FILL_LEVEL, q_a.size());
    end
    checks++;
    if (if_a.DROP_ERR !== exp_drop_a) begin
      errors++; $display("FAIL a_drop_err got %b exp %b", if_a.DROP_ERR, exp_drop_a);
    end
    for (int i = 0; i < n; i++) void'(q_a.pop_front());
    acc = valid && exp_rdy;
    if (acc) for (int i = 66; i >= 0; i--) q_a.push_back(data[i]);
    exp_drop_a = valid && !exp_rdy;
  endtask

  // One cycle on instance C (66b in, 32b out), same scheme as step_a.
  task automatic step_c(input bit valid, input logic [65:0] data, output bit acc);
    logic [31:0] exp_word;
    bit exp_rdy;
    int n;
    @(negedge clk);
    if_c.DATA_IN       = data;
    if_c.DATA_IN_VALID = valid;
    #1;
    n = (q_c.size() < 32) ? q_c.size() : 32;
    exp_word = '0;
    for (int i = 0; i < n; i++) exp_word[31-i] = q_c[i];
    exp_rdy = (q_c.size() <= 63);
    checks++;
    if (if_c.DATA_OUT !== exp_word) begin
      errors++; $display("FAIL c_data_out got %h exp %h", if_c.DATA_OUT, exp_word);
    end
    checks++;
    if (if_c.DATA_IN_READY !== exp_rdy) begin
      errors++; $display("FAIL c_ready got %b exp %b", if_c.DATA_IN_READY, exp_rdy);
    end
    checks++;
    if (if_c.FILL_LEVEL !== 7'(q_c.size()) || if_c.DROP_ERR !== exp_drop_c) begin
      errors++; $display("FAIL c_fill_drop got %0d/%b exp %0d/%b",
                         if_c.FILL_LEVEL, if_c.DROP_ERR, q_c.size(), exp_drop_c);
    end
    for (int i = 0; i < n; i++) void'(q_c.pop_front());
    acc = valid && exp_rdy;
    if (acc) for (int i = 65; i >= 0; i--) q_c.push_back(data[i]);
    exp_drop_c = valid && !exp_rdy;
  endtask

  task automatic reset_a();
    @(negedge clk);
    rst_a = 1'b1;
    if_a.DATA_IN_VALID = 1'b0;
    @(negedge clk);
    rst_a = 1'b0;
    q_a.delete();
    exp_drop_a = 1'b0;
  endtask

  task automatic test_reset();
    reset_a();
    #1;
    checks++;
    if (if_a.DATA_OUT !== 20'h0 || if_a.DATA_IN_READY !== 1'b1 || if_a.UNDERFLOW !== 1'b1 ||
        if_a.FILL_LEVEL !== 7'd0 || if_a.DROP_ERR !== 1'b0) begin
      errors++;
      $display("FAIL reset_state got out=%h rdy=%b uf=%b fill=%0d drop=%b", if_a.DATA_OUT,
               if_a.DATA_IN_READY, if_a.UNDERFLOW, if_a.FILL_LEVEL, if_a.DROP_ERR);
    end
  endtask

  task automatic test_const_valid();
    int fill_tbl[12] = '{0, 67, 47, 27, 74, 54, 34, 81, 61, 41, 21, 68};
    bit exp_rdy;
    reset_a();
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if_a.DATA_IN       = 67'h2_DEAD_BEEF_0123_4567;
      if_a.DATA_IN_VALID = 1'b1;
      #1;
      exp_rdy = (fill_tbl[i] == 0) || (fill_tbl[i] == 27) || (fill_tbl[i] == 34) ||
                (fill_tbl[i] == 21);
      checks++;
      if (if_a.FILL_LEVEL !== 7'(fill_tbl[i]) || if_a.DATA_IN_READY !== exp_rdy ||
          if_a.UNDERFLOW !== (i == 0)) begin
        errors++;
        $display("FAIL const_seq[%0d] got fill=%0d rdy=%b uf=%b exp fill=%0d rdy=%b uf=%b", i,
                 if_a.FILL_LEVEL, if_a.DATA_IN_READY, if_a.UNDERFLOW, fill_tbl[i], exp_rdy, i == 0);
      end
    end
  endtask

  task automatic test_stream();
    logic [66:0] pay = 67'h5_1234_5678_9ABC_DEF0;
    int accepts = 0;
    int uf = 0;
    bit acc;
    reset_a();
    for (int i = 0; i < 670; i++) begin
      step_a(1'b1, pay, acc);
      if (i > 0 && if_a.UNDERFLOW) uf++;
      if (acc) begin
        accepts++;
        pay = pay + 67'h1_0000_0001_0000_0003;
      end
    end
    for (int i = 0; i < 8; i++) step_a(1'b0, 67'h0, acc);
    checks++;
    if (accepts != 200) begin
      errors++; $display("FAIL stream_accepts got %0d exp 200", accepts);
    end
    checks++;
    if (uf != 0) begin
      errors++; $display("FAIL stream_underflow got %0d exp 0", uf);
    end
  endtask

  task automatic test_single();
    logic [19:0] out_tbl[5] = '{20'hFFFFF, 20'hFFFFF, 20'hFFFFF, 20'hFE000, 20'h00000};
    int fill_tbl[5] = '{67, 47, 27, 7, 0};
    bit uf_tbl[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    bit acc;
    reset_a();
    step_a(1'b1, 67'h7_FFFF_FFFF_FFFF_FFFF, acc);
    for (int i = 0; i < 5; i++) begin
      step_a(1'b0, 67'h0, acc);
      checks++;
      if (if_a.DATA_OUT !== out_tbl[i] || if_a.FILL_LEVEL !== 7'(fill_tbl[i]) ||
          if_a.UNDERFLOW !== uf_tbl[i]) begin
        errors++;
        $display("FAIL single[%0d] got out=%h fill=%0d uf=%b exp out=%h fill=%0d uf=%b", i,
                 if_a.DATA_OUT, if_a.FILL_LEVEL, if_a.UNDERFLOW, out_tbl[i], fill_tbl[i], uf_tbl[i]);
      end
    end
  endtask

  task automatic test_drop();
    bit acc;
    reset_a();
    step_a(1'b1, 67'h1_2345_6789_ABCD_EF01, acc);
    step_a(1'b0, 67'h0, acc);
    step_a(1'b1, 67'h7_0F0F_0F0F_0F0F_0F0F, acc);
    step_a(1'b0, 67'h0, acc);
    checks++;
    if (if_a.DROP_ERR !== 1'b1 || if_a.FILL_LEVEL !== 7'd27) begin
      errors++;
      $display("FAIL drop_pulse got drop=%b fill=%0d exp drop=1 fill=27", if_a.DROP_ERR,
               if_a.FILL_LEVEL);
    end
    for (int i = 0; i < 3; i++) step_a(1'b0, 67'h0, acc);
  endtask

  task automatic test_mid_reset();
    bit acc;
    reset_a();
    for (int i = 0; i < 5; i++) step_a(1'b1, 67'h3_CAFE_F00D_1357_9BDF, acc);
    @(negedge clk);
    #1;
    checks++;
    if (if_a.FILL_LEVEL !== 7'd54) begin
      errors++; $display("FAIL midreset_pre got fill=%0d exp 54", if_a.FILL_LEVEL);
    end
    rst_a = 1'b1;
    if_a.DATA_IN_VALID = 1'b1;
    @(negedge clk);
    rst_a = 1'b0;
    if_a.DATA_IN_VALID = 1'b0;
    #1;
    checks++;
    if (if_a.DATA_OUT !== 20'h0 || if_a.FILL_LEVEL !== 7'd0 || if_a.DATA_IN_READY !== 1'b1 ||
        if_a.DROP_ERR !== 1'b0) begin
      errors++;
      $display("FAIL midreset_post got out=%h fill=%0d rdy=%b drop=%b", if_a.DATA_OUT,
               if_a.FILL_LEVEL, if_a.DATA_IN_READY, if_a.DROP_ERR);
    end
    q_a.delete();
    exp_drop_a = 1'b0;
  endtask

  task automatic test_reverse();
    logic [19:0] src = 20'h12345;
    logic [19:0] exp_rev;
    for (int i = 0; i < 20; i++) exp_rev[i] = src[19-i];
    @(negedge clk);
    rst_b = 1'b1;
    if_b.DATA_IN_VALID = 1'b0;
    @(negedge clk);
    rst_b = 1'b0;
    if_b.DATA_IN       = 67'h4_0000_0000_0000_0000;
    if_b.DATA_IN_VALID = 1'b1;
    @(negedge clk);
    if_b.DATA_IN_VALID = 1'b0;
    #1;
    checks++;
    if (if_b.DATA_OUT !== 20'h00001 || if_b.FILL_LEVEL !== 7'd67) begin
      errors++; $display("FAIL reverse_msb got out=%h fill=%0d exp 00001/67", if_b.DATA_OUT,
                         if_b.FILL_LEVEL);
    end
    repeat (4) @(negedge clk);
    if_b.DATA_IN       = {src, 47'h0};
    if_b.DATA_IN_VALID = 1'b1;
    @(negedge clk);
    if_b.DATA_IN_VALID = 1'b0;
    #1;
    checks++;
    if (if_b.DATA_OUT !== exp_rev) begin
      errors++; $display("FAIL reverse_word got %h exp %h", if_b.DATA_OUT, exp_rev);
    end
  endtask

  task automatic test_stream_c();
    logic [65:0] pay = 66'h2_8765_4321_0FED_CBA9;
    int accepts = 0;
    int uf = 0;
    bit acc;
    @(negedge clk);
    rst_c = 1'b1;
    if_c.DATA_IN_VALID = 1'b0;
    @(negedge clk);
    rst_c = 1'b0;
    q_c.delete();
    exp_drop_c = 1'b0;
    for (int i = 0; i < 330; i++) begin
      step_c(1'b1, pay, acc);
      if (i > 0 && if_c.UNDERFLOW) uf++;
      if (acc) begin
        accepts++;
        pay = pay + 66'h0_0000_0005_0000_0007;
      end
    end
    for (int i = 0; i < 6; i++) step_c(1'b0, 66'h0, acc);
    checks++;
    if (accepts != 160 || uf != 0) begin
      errors++; $display("FAIL c_stream got accepts=%0d uf=%0d exp 160/0", accepts, uf);
    end
  endtask

  initial begin
    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
    if_a.DATA_IN = '0; if_a.DATA_IN_VALID = 1'b0;
    if_b.DATA_IN = '0; if_b.DATA_IN_VALID = 1'b0;
    if_c.DATA_IN = '0; if_c.DATA_IN_VALID = 1'b0;
    repeat (2) @(negedge clk);
    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
    test_reset();
    test_const_valid();
    test_stream();
    test_single();
    test_drop();
    test_mid_reset();
    test_reverse();
    test_stream_c();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
